sram_port_arbiter: RTL



---
 rtl/sram_port_arbiter_if.sv | 36 +++
 rtl/sram_port_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester and SRAM-macro bundle for sram_port_arbiter
// The master side is the clients plus the SRAM macro; the slave side is the arbiter.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            wr_req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]            wr_gnt;
    logic [NUM_REQ-1:0]            rd_req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_REQ-1:0]            rd_gnt;
    logic [NUM_REQ-1:0]            rd_rsp_valid;
    logic [DATA_WIDTH-1:0]         rd_rsp_data;
    logic                          init_done;
    logic                          ram_csb0;
    logic [ADDR_WIDTH-1:0]         ram_addr0;
    logic [DATA_WIDTH-1:0]         ram_din0;
    logic                          ram_csb1;
    logic [ADDR_WIDTH-1:0]         ram_addr1;
    logic [DATA_WIDTH-1:0]         ram_dout1;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_dout1,
        input  wr_gnt, rd_gnt, rd_rsp_valid, rd_rsp_data, init_done,
        input  ram_csb0, ram_addr0, ram_din0, ram_csb1, ram_addr1
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_dout1,
        output wr_gnt, rd_gnt, rd_rsp_valid, rd_rsp_data, init_done,
        output ram_csb0, ram_addr0, ram_din0, ram_csb1, ram_addr1
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin write/read port arbiter for a 1W1R SRAM macro
// Zero-fills the macro after reset, then arbitrates both ports and routes read data back.
module sram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 256,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arbiter_if.slave   bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [NUM_REQ-1:0]      r_rd_pend;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_data;

    logic [ADDR_WIDTH-1:0]   w_wr_addr_a [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_wr_data_a [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   w_rd_addr_a [NUM_REQ];

    logic                    w_wr_found;
    logic                    w_rd_found;
    logic [PW-1:0]           w_wr_idx;
    logic [PW-1:0]           w_rd_idx;
    logic [PW-1:0]           w_j_wr;
    logic [PW-1:0]           w_j_rd;
    logic [NUM_REQ-1:0]      w_wr_gnt;
    logic [NUM_REQ-1:0]      w_rd_gnt;
    logic                    w_csb0;
    logic [ADDR_WIDTH-1:0]   w_addr0;
    logic [DATA_WIDTH-1:0]   w_din0;
    logic                    w_csb1;
    logic [ADDR_WIDTH-1:0]   w_addr1;
    logic                    w_wr_acc;
    logic                    w_rd_acc;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_wr_addr_a[g] = bus.wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wr_data_a[g] = bus.wr_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_rd_addr_a[g] = bus.rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // First asserted request at or after each pointer, scanning upward with wrap.
    always_comb begin
        w_wr_found = 1'b0;
        w_rd_found = 1'b0;
        w_wr_idx   = '0;
        w_rd_idx   = '0;
        w_j_wr     = '0;
        w_j_rd     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j_wr = PW'((int'(r_wr_ptr) + k) % NUM_REQ);
            w_j_rd = PW'((int'(r_rd_ptr) + k) % NUM_REQ);
            if (!w_wr_found && bus.wr_req[w_j_wr]) begin
                w_wr_found = 1'b1;
                w_wr_idx   = w_j_wr;
            end
            if (!w_rd_found && bus.rd_req[w_j_rd]) begin
                w_rd_found = 1'b1;
                w_rd_idx   = w_j_rd;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_gnt    = '0;
        w_rd_gnt    = '0;
        w_csb0      = 1'b1;
        w_addr0     = '0;
        w_din0      = '0;
        w_csb1      = 1'b1;
        w_addr1     = '0;
        w_wr_acc    = 1'b0;
        w_rd_acc    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_csb0  = 1'b0;
                w_addr0 = r_init_cnt;
                if (r_init_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_wr_found) begin
                    w_wr_gnt[w_wr_idx] = 1'b1;
                    w_csb0             = 1'b0;
                    w_addr0            = w_wr_addr_a[w_wr_idx];
                    w_din0             = w_wr_data_a[w_wr_idx];
                    w_wr_acc           = 1'b1;
                end
                // A same-address read waits a cycle so it observes the new write data.
                if (w_rd_found &&
                    !(w_wr_found && (w_rd_addr_a[w_rd_idx] == w_wr_addr_a[w_wr_idx]))) begin
                    w_rd_gnt[w_rd_idx] = 1'b1;
                    w_csb1             = 1'b0;
                    w_addr1            = w_rd_addr_a[w_rd_idx];
                    w_rd_acc           = 1'b1;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT_ZERO ? ST_INIT : ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_pend   <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            if (w_wr_acc) begin
                r_wr_ptr <= (w_wr_idx == PW'(NUM_REQ - 1)) ? '0 : w_wr_idx + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (w_rd_idx == PW'(NUM_REQ - 1)) ? '0 : w_rd_idx + 1'b1;
            end
            // The macro presents dout1 the cycle after the read; capture it one edge later.
            r_rd_pend   <= w_rd_gnt;
            r_rsp_valid <= r_rd_pend;
            if (|r_rd_pend) begin
                r_rsp_data <= bus.ram_dout1;
            end
        end
    end

    assign bus.wr_gnt       = w_wr_gnt;
    assign bus.rd_gnt       = w_rd_gnt;
    assign bus.ram_csb0     = w_csb0;
    assign bus.ram_addr0    = w_addr0;
    assign bus.ram_din0     = w_din0;
    assign bus.ram_csb1     = w_csb1;
    assign bus.ram_addr1    = w_addr1;
    assign bus.rd_rsp_valid = r_rsp_valid;
    assign bus.rd_rsp_data  = r_rsp_data;
    assign bus.init_done    = (r_state == ST_RUN);
endmodule
